// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with programmable almost-empty /
// almost-full thresholds, occupancy reporting and overflow/underflow detection.
// DEPTH = 2**ADDR_WIDTH entries of DATA_WIDTH bits. Read data is registered.
// Optional build macro FIFO_STICKY_ERR_EN: error flags become sticky and are
// cleared by err_clr; without it they are single-cycle pulses.
module fifo_param #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  pause,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic                  pop_ok;
    logic                  push_ok;
    logic                  ovf_now;
    logic                  unf_now;
    logic [ADDR_WIDTH:0]   count_nxt;

    // Occupancy after this edge: +1 / -1 / hold depending on accepted ops.
    function automatic logic [ADDR_WIDTH:0] next_count(
        input logic [ADDR_WIDTH:0] cur,
        input logic                wr,
        input logic                rd
    );
        logic [ADDR_WIDTH:0] res;
        res = cur;
        if (wr && !rd)
            res = cur + 1'b1;
        else if (rd && !wr)
            res = cur - 1'b1;
        return res;
    endfunction

    // Acceptance: a full FIFO still takes a push when a pop frees a slot in
    // the same cycle; an empty FIFO never bypasses data to a same-cycle pop.
    always_comb begin
        pop_ok    = pop && (count != '0);
        push_ok   = push && ((count != DEPTH_C) || pop_ok);
        ovf_now   = push && !push_ok;
        unf_now   = pop && !pop_ok;
        count_nxt = next_count(count, push_ok, pop_ok);
    end

    // Storage array: written only on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            mem[wr_ptr] <= data_in;
    end

    // Pointers, registered read data, occupancy, status flags and errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            data_out      <= '0;
            valid_out     <= 1'b0;
            count         <= '0;
            fifo_empty    <= 1'b1;
            fifo_full     <= 1'b0;
            almost_empty  <= 1'b0;
            almost_full   <= 1'b0;
            pause         <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            valid_out    <= pop_ok;
            count        <= count_nxt;
            fifo_empty   <= (count_nxt == '0);
            fifo_full    <= (count_nxt == DEPTH_C);
            almost_empty <= (count_nxt != '0) && (count_nxt <= ae_thresh);
            almost_full  <= (count_nxt != DEPTH_C) && (count_nxt >= af_thresh);
            pause        <= (count_nxt >= af_thresh);
`ifdef FIFO_STICKY_ERR_EN
            // A new error in the same cycle as err_clr keeps the bit set.
            overflow_err  <= ovf_now || (overflow_err && !err_clr);
            underflow_err <= unf_now || (underflow_err && !err_clr);
`else
            overflow_err  <= ovf_now;
            underflow_err <= unf_now;
`endif
        end
    end

`ifndef FIFO_STICKY_ERR_EN
    // err_clr only matters for sticky errors.
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed scoreboard bench for fifo_param (DATA_WIDTH=6,
// ADDR_WIDTH=2). A queue model holds expected contents; each popped entry is
// compared when valid_out appears. Honours FIFO_STICKY_ERR_EN if defined.
module tb_fifo_param;

    localparam int DW    = 6;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [AW:0]   ae_thresh;
    logic [AW:0]   af_thresh;
    logic          err_clr;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_empty;
    logic          almost_full;
    logic          pause;
    logic          overflow_err;
    logic          underflow_err;

    fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .ae_thresh    (ae_thresh),
        .af_thresh    (af_thresh),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .count        (count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .pause        (pause),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] last_d  = '0;
    logic          exp_v   = 1'b0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge, check all outputs.
    task automatic cycle(input string step, input logic pu, input logic po,
                         input logic [DW-1:0] d, input logic clr);
        int   sz;
        int   cnt;
        logic pop_ok;
        logic push_ok;
        logic ovf_new;
        logic unf_new;
        push    = pu;
        pop     = po;
        data_in = d;
        err_clr = clr;
        sz      = mq.size();
        pop_ok  = po && (sz != 0);
        push_ok = pu && ((sz != DEPTH) || pop_ok);
        ovf_new = pu && !push_ok;
        unf_new = po && !pop_ok;
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            last_d  = '0;
            exp_v   = 1'b0;
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_v = pop_ok;
            if (pop_ok)
                last_d = mq.pop_front();
            if (push_ok)
                mq.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
            exp_ovf = ovf_new || (exp_ovf && !clr);
            exp_unf = unf_new || (exp_unf && !clr);
`else
            exp_ovf = ovf_new;
            exp_unf = unf_new;
`endif
        end
        cnt = mq.size();
        chk({step, ".count"},         int'(count),         cnt);
        chk({step, ".fifo_empty"},    int'(fifo_empty),    int'(cnt == 0));
        chk({step, ".fifo_full"},     int'(fifo_full),     int'(cnt == DEPTH));
        chk({step, ".almost_empty"},  int'(almost_empty),  int'(cnt != 0 && cnt <= int'(ae_thresh)));
        chk({step, ".almost_full"},   int'(almost_full),   int'(!reset && cnt != DEPTH && cnt >= int'(af_thresh)));
        chk({step, ".pause"},         int'(pause),         int'(!reset && cnt >= int'(af_thresh)));
        chk({step, ".valid_out"},     int'(valid_out),     int'(exp_v));
        chk({step, ".data_out"},      int'(data_out),      int'(last_d));
        chk({step, ".overflow_err"},  int'(overflow_err),  int'(exp_ovf));
        chk({step, ".underflow_err"}, int'(underflow_err), int'(exp_unf));
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        data_in   = '0;
        err_clr   = 1'b0;
        ae_thresh = 3'd1;
        af_thresh = 3'd3;

        // Reset state
        cycle("rst0", 1'b0, 1'b0, 6'h00, 1'b0);
        cycle("rst1", 1'b1, 1'b1, 6'h3F, 1'b0);
        reset = 1'b0;
        cycle("idle", 1'b0, 1'b0, 6'h00, 1'b0);

        // Fill and drain
        for (int i = 1; i <= 4; i++) begin
            cycle("fill", 1'b1, 1'b0, 6'(i), 1'b0);
            if (i == 3) chk("fill3.pause_const", int'(pause), 1);
            if (i == 4) chk("fill4.af_low_at_full", int'(almost_full), 0);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle("drain", 1'b0, 1'b1, 6'h00, 1'b0);
            chk("drain.value", int'(data_out), i);
        end
        cycle("drain_hold", 1'b0, 1'b0, 6'h00, 1'b0);

        // Overflow on a full FIFO
        for (int i = 5; i <= 8; i++) cycle("ovf_fill", 1'b1, 1'b0, 6'(i), 1'b0);
        cycle("ovf", 1'b1, 1'b0, 6'h3F, 1'b0);
        chk("ovf.pulse", int'(overflow_err), 1);
        cycle("ovf_after", 1'b0, 1'b0, 6'h00, 1'b0);
        for (int i = 0; i < 4; i++) cycle("ovf_drain", 1'b0, 1'b1, 6'h00, 1'b0);

        // Underflow and push+pop on empty
        cycle("unf", 1'b0, 1'b1, 6'h00, 1'b0);
        chk("unf.pulse", int'(underflow_err), 1);
        cycle("empty_pp", 1'b1, 1'b1, 6'h15, 1'b0);
        chk("empty_pp.count", int'(count), 1);
        cycle("empty_pp_drain", 1'b0, 1'b1, 6'h00, 1'b0);
        chk("empty_pp.data", int'(data_out), 'h15);

        // Push+pop on full, then pointer wrap
        for (int i = 0; i < 4; i++) cycle("full_fill", 1'b1, 1'b0, 6'(8'h11 + i), 1'b0);
        cycle("full_pp", 1'b1, 1'b1, 6'h2A, 1'b0);
        chk("full_pp.oldest", int'(data_out), 'h11);
        for (int i = 0; i < 3; i++) cycle("full_pp_drain", 1'b0, 1'b1, 6'h00, 1'b0);
        cycle("wrap", 1'b0, 1'b1, 6'h00, 1'b0);
        chk("wrap.data", int'(data_out), 'h2A);

        // Mid-stream reset with count = 2
        cycle("mid_fill", 1'b1, 1'b0, 6'h31, 1'b0);
        cycle("mid_fill", 1'b1, 1'b0, 6'h32, 1'b0);
        reset = 1'b1;
        cycle("mid_rst", 1'b1, 1'b1, 6'h33, 1'b0);
        reset = 1'b0;
        cycle("post_rst_pop", 1'b0, 1'b1, 6'h00, 1'b0);
        chk("post_rst.unf", int'(underflow_err), 1);

        // Threshold edge cases
        af_thresh = 3'd0;
        cycle("af0", 1'b0, 1'b0, 6'h00, 1'b0);
        chk("af0.pause_empty", int'(pause), 1);
        af_thresh = 3'd5;
        ae_thresh = 3'd4;
        for (int i = 0; i < 4; i++) cycle("af5_fill", 1'b1, 1'b0, 6'(8'h20 + i), 1'b0);
        chk("af5.pause_full", int'(pause), 0);
        for (int i = 0; i < 4; i++) cycle("af5_drain", 1'b0, 1'b1, 6'h00, 1'b0);
        ae_thresh = 3'd1;
        af_thresh = 3'd3;

        // Error persistence and err_clr
        cycle("err_unf", 1'b0, 1'b1, 6'h00, 1'b0);
        for (int i = 0; i < 5; i++) cycle("err_idle", 1'b0, 1'b0, 6'h00, 1'b0);
        cycle("err_clr", 1'b0, 1'b0, 6'h00, 1'b1);
        chk("err_clr.cleared", int'(underflow_err), 0);
        cycle("err_unf2", 1'b0, 1'b1, 6'h00, 1'b0);
        cycle("err_clr_vs_new", 1'b0, 1'b1, 6'h00, 1'b1);
        chk("err_clr_vs_new.set", int'(underflow_err), 1);
        cycle("err_clr2", 1'b0, 1'b0, 6'h00, 1'b1);

        // Random traffic
        for (int i = 0; i < 60; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5; i++) cycle("final_drain", 1'b0, 1'b1, 6'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
